// File: rtl/evict_stack_buf.sv
`default_nettype none
// ==========================================================================
// evict_stack_buf : LIFO of eviction frames {state, addr, line, smac} with
// replace, flush and sticky overflow alert. Optional EVICT_STACK_HIGHWATER_EN
// adds the max_count high-water output.                          Rev 1.0
// ==========================================================================
module evict_stack_buf #(
  parameter int DEPTH    = 8,
  parameter int STATE_W  = 6,
  parameter int ADDR_W   = 64,
  parameter int LINE_W   = 512,
  parameter int SMAC_W   = 128,
  localparam int FRAME_W = STATE_W + ADDR_W + LINE_W + SMAC_W,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [FRAME_W-1:0] push_frame,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [FRAME_W-1:0] top_frame,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               overflow_alert
`ifdef EVICT_STACK_HIGHWATER_EN
  ,
  output logic [CNT_W-1:0]   max_count
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]   sp_q, sp_d;
  logic [FRAME_W-1:0] top_q, top_d;
  logic               ovf_q, ovf_d;

  logic               push_fire;
  logic               pop_fire;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [FRAME_W-1:0] below_frame;

  assign push_ready = (sp_q < DEPTH_C) || pop_ready;
  assign pop_valid  = (sp_q != '0);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;
  assign wr_en      = push_fire && !flush && rst_n;

  // A replace overwrites the current top slot instead of the next free one.
  assign wr_ptr = pop_fire ? (sp_q - ONE_C) : sp_q;
  assign rd_ptr = sp_q - TWO_C;

  // rd_ptr wraps to an out-of-range value when sp is 0 or 1, so no slot matches.
  always_comb begin
    below_frame = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == CNT_W'(i)) begin
        below_frame = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ptr == CNT_W'(i)) begin
          mem_q[i] <= push_frame;
        end
      end
    end
  end

  always_comb begin
    sp_d  = sp_q;
    top_d = top_q;
    ovf_d = ovf_q | (push_valid & ~push_ready);
    if (flush) begin
      sp_d  = '0;
      top_d = '0;
    end else if (push_fire && pop_fire) begin
      top_d = push_frame;
    end else if (push_fire) begin
      sp_d  = sp_q + ONE_C;
      top_d = push_frame;
    end else if (pop_fire) begin
      sp_d  = sp_q - ONE_C;
      top_d = (sp_q == ONE_C) ? '0 : below_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
    end
  end

  assign count          = sp_q;
  assign top_frame      = top_q;
  assign overflow_alert = ovf_q;

`ifdef EVICT_STACK_HIGHWATER_EN
  logic [CNT_W-1:0] max_q, max_d;

  assign max_d = (sp_d > max_q) ? sp_d : max_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_count = max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_evict_stack_buf.sv
`default_nettype none
// ==========================================================================
// tb_evict_stack_buf : directed scenarios plus random traffic against a
// queue-based LIFO model.                                         Rev 1.0
// ==========================================================================
module tb_evict_stack_buf;

  localparam int DEPTH = 8;
  localparam int FW    = 6 + 64 + 512 + 128;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AOFF  = 512 + 128;

  typedef logic [FW-1:0] frame_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_valid = 1'b0;
  logic             push_ready;
  frame_t           push_frame = '0;
  logic             pop_valid;
  logic             pop_ready = 1'b0;
  frame_t           top_frame;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;
  logic             overflow_alert;
`ifdef EVICT_STACK_HIGHWATER_EN
  logic [CNT_W-1:0] max_count;
`endif

  int vecs = 0;
  int errs = 0;

  // Reference model
  frame_t mq[$];
  bit     m_ovf = 1'b0;
  int     m_max = 0;

  always #5 clk = ~clk;

  evict_stack_buf #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_frame     (push_frame),
    .pop_valid      (pop_valid),
    .pop_ready      (pop_ready),
    .top_frame      (top_frame),
    .flush          (flush),
    .count          (count),
    .overflow_alert (overflow_alert)
`ifdef EVICT_STACK_HIGHWATER_EN
    ,
    .max_count      (max_count)
`endif
  );

  function automatic frame_t mk(input logic [63:0] addr);
    frame_t f;
    f = '0;
    for (int i = 0; i < 23; i++) f = {f[FW-33:0], $urandom()};
    f[AOFF +: 64] = addr;
    return f;
  endfunction

  function automatic frame_t m_top();
    return (mq.size() != 0) ? mq[mq.size()-1] : '0;
  endfunction

  task automatic set_in(input bit pv, input bit pr, input bit fl, input frame_t fr);
    push_valid = pv;
    pop_ready  = pr;
    flush      = fl;
    push_frame = fr;
    #1;
  endtask

  // Advance model with the current inputs, then clock the DUT.
  task automatic tick();
    bit rdy, pf, of;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_max = 0;
    end else begin
      rdy = (mq.size() < DEPTH) || pop_ready;
      if (push_valid && !rdy) m_ovf = 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        pf = push_valid && rdy;
        of = (mq.size() != 0) && pop_ready;
        if (pf && of) mq[mq.size()-1] = push_frame;
        else if (pf) mq.push_back(push_frame);
        else if (of) void'(mq.pop_back());
      end
      if (mq.size() > m_max) m_max = mq.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic [63:0] addr);
    set_in(1'b1, 1'b0, 1'b0, mk(addr));
    tick();
    idle();
  endtask

  task automatic pop();
    set_in(1'b0, 1'b1, 1'b0, '0);
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    vecs++; if (count !== '0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (pop_valid !== 1'b0) begin errs++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
    vecs++; if (push_ready !== 1'b1) begin errs++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    vecs++; if (top_frame !== '0) begin errs++; $display("FAIL reset_top got %h want 0", top_frame[AOFF +: 64]); end
    vecs++; if (overflow_alert !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", overflow_alert); end
`ifdef EVICT_STACK_HIGHWATER_EN
    vecs++; if (max_count !== '0) begin errs++; $display("FAIL reset_max got %0d want 0", max_count); end
`endif
  endtask

  task automatic test_lifo();
    logic [63:0] want;
    do_reset();
    push(64'h10);
    push(64'h20);
    push(64'h30);
    vecs++; if (count !== 4'd3) begin errs++; $display("FAIL lifo_count got %0d want 3", count); end
    for (int k = 0; k < 3; k++) begin
      want = 64'h30 - 64'h10 * k;
      vecs++; if (top_frame[AOFF +: 64] !== want) begin errs++; $display("FAIL lifo_addr%0d got %h want %h", k, top_frame[AOFF +: 64], want); end
      vecs++; if (top_frame !== m_top()) begin errs++; $display("FAIL lifo_frame%0d got %h want %h", k, top_frame[AOFF +: 64], m_top() >> AOFF); end
      pop();
    end
    vecs++; if (pop_valid !== 1'b0) begin errs++; $display("FAIL lifo_empty_valid got %b want 0", pop_valid); end
    vecs++; if (top_frame !== '0) begin errs++; $display("FAIL lifo_empty_top got %h want 0", top_frame[AOFF +: 64]); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(64'h100 + 64'(i));
    vecs++; if (count !== 4'd8) begin errs++; $display("FAIL full_count got %0d want 8", count); end
    vecs++; if (push_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %b want 0", push_ready); end
    set_in(1'b1, 1'b0, 1'b0, mk(64'hdead));
    tick();
    idle();
    vecs++; if (overflow_alert !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", overflow_alert); end
    vecs++; if (count !== 4'd8) begin errs++; $display("FAIL ovf_count got %0d want 8", count); end
    vecs++; if (top_frame !== m_top()) begin errs++; $display("FAIL ovf_top got %h want %h", top_frame[AOFF +: 64], 64'h107); end
    set_in(1'b0, 1'b0, 1'b1, '0);
    tick();
    idle();
    vecs++; if (overflow_alert !== 1'b1) begin errs++; $display("FAIL ovf_after_flush got %b want 1", overflow_alert); end
    vecs++; if (count !== '0) begin errs++; $display("FAIL flush_count got %0d want 0", count); end
  endtask

  task automatic test_replace();
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) push(64'h40 + 64'(i));
    push(64'h80);
    vecs++; if (top_frame[AOFF +: 64] !== 64'h80) begin errs++; $display("FAIL repl_pre_top got %h want 80", top_frame[AOFF +: 64]); end
    set_in(1'b1, 1'b1, 1'b0, mk(64'h99));
    vecs++; if (push_ready !== 1'b1) begin errs++; $display("FAIL repl_ready got %b want 1", push_ready); end
    tick();
    idle();
    vecs++; if (count !== 4'd8) begin errs++; $display("FAIL repl_count got %0d want 8", count); end
    vecs++; if (top_frame[AOFF +: 64] !== 64'h99) begin errs++; $display("FAIL repl_top got %h want 99", top_frame[AOFF +: 64]); end
    vecs++; if (overflow_alert !== 1'b0) begin errs++; $display("FAIL repl_ovf got %b want 0", overflow_alert); end
    pop();
    vecs++; if (top_frame[AOFF +: 64] !== 64'h46) begin errs++; $display("FAIL repl_below got %h want 46", top_frame[AOFF +: 64]); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    push(64'h1);
    push(64'h2);
    push(64'h3);
    set_in(1'b1, 1'b1, 1'b1, mk(64'h55));
    tick();
    idle();
    vecs++; if (count !== '0) begin errs++; $display("FAIL flushp_count got %0d want 0", count); end
    vecs++; if (pop_valid !== 1'b0) begin errs++; $display("FAIL flushp_valid got %b want 0", pop_valid); end
    vecs++; if (top_frame !== '0) begin errs++; $display("FAIL flushp_top got %h want 0", top_frame[AOFF +: 64]); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) push(64'h200 + 64'(i));
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, mk(64'h66));
    tick();
    rst_n = 1'b1;
    idle();
    vecs++; if (count !== '0) begin errs++; $display("FAIL rstmid_count got %0d want 0", count); end
    vecs++; if (top_frame !== '0) begin errs++; $display("FAIL rstmid_top got %h want 0", top_frame[AOFF +: 64]); end
    push(64'h77);
    vecs++; if (count !== 4'd1) begin errs++; $display("FAIL rstmid_push_count got %0d want 1", count); end
    vecs++; if (top_frame[AOFF +: 64] !== 64'h77) begin errs++; $display("FAIL rstmid_push_top got %h want 77", top_frame[AOFF +: 64]); end
  endtask

`ifdef EVICT_STACK_HIGHWATER_EN
  task automatic test_highwater();
    do_reset();
    for (int i = 0; i < 6; i++) push(64'h300 + 64'(i));
    for (int i = 0; i < 4; i++) pop();
    push(64'h399);
    vecs++; if (max_count !== 4'd6) begin errs++; $display("FAIL hw_max got %0d want 6", max_count); end
    vecs++; if (count !== 4'd3) begin errs++; $display("FAIL hw_count got %0d want 3", count); end
    set_in(1'b0, 1'b0, 1'b1, '0);
    tick();
    idle();
    vecs++; if (max_count !== 4'd6) begin errs++; $display("FAIL hw_after_flush got %0d want 6", max_count); end
  endtask
`endif

  task automatic test_random();
    bit pv, pr, fl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom() % 4) != 0;
      pr = (i < 200) ? (($urandom() % 2) == 0) : (($urandom() % 3) == 0);
      fl = ($urandom() % 40) == 0;
      set_in(pv, pr, fl, mk(64'($urandom())));
      vecs++; if (push_ready !== ((mq.size() < DEPTH) || pr)) begin errs++; $display("FAIL rnd_ready cyc %0d got %b size %0d pr %b", i, push_ready, mq.size(), pr); end
      vecs++; if (pop_valid !== (mq.size() != 0)) begin errs++; $display("FAIL rnd_valid cyc %0d got %b size %0d", i, pop_valid, mq.size()); end
      tick();
      vecs++; if (count !== CNT_W'(mq.size())) begin errs++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, mq.size()); end
      vecs++; if (top_frame !== m_top()) begin errs++; $display("FAIL rnd_top cyc %0d got %h want %h", i, top_frame[AOFF +: 64], m_top() >> AOFF); end
      vecs++; if (overflow_alert !== m_ovf) begin errs++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, overflow_alert, m_ovf); end
`ifdef EVICT_STACK_HIGHWATER_EN
      vecs++; if (max_count !== CNT_W'(m_max)) begin errs++; $display("FAIL rnd_max cyc %0d got %0d want %0d", i, max_count, m_max); end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_full_overflow();
    test_replace();
    test_flush_priority();
    test_reset_midstream();
`ifdef EVICT_STACK_HIGHWATER_EN
    test_highwater();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
